// File: rtl/demux_hold_n_pkg.sv
// Shared constants for the registered 1-to-N demultiplexer: channel-state encoding,
// error-counter sizing and address-range helper.
package demux_hold_n_pkg;

  localparam int ERR_W        = 8;
  localparam int CHANNELS_DEF = 4;
  localparam int ADDR_MAX     = CHANNELS_DEF - 1;

  typedef logic [0:0] chan_state_t;

  localparam chan_state_t EMPTY = 1'b0;
  localparam chan_state_t FULL  = 1'b1;

  localparam logic [ERR_W-1:0] ERR_SAT = '1;

  // Highest legal channel index for a given channel count.
  function automatic int addr_max(input int channels);
    return channels - 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry output buffer for one demux channel. The state register doubles as
// the channel's valid flag and is exposed for observation.
module demux_slot
  import demux_hold_n_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output chan_state_t      state
);

  chan_state_t state_q;
  logic        consume;

  assign consume  = (state_q == FULL) && rd_ready;
  // A full slot can still take a word in the same cycle its consumer drains it.
  assign wr_ready = (state_q == EMPTY) || rd_ready;
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rd_data <= '0;
    end else if (wr_en) begin
      state_q <= FULL;
      rd_data <= wr_data;
    end else if (consume) begin
      state_q <= EMPTY;
      if (!HOLD_LAST) rd_data <= '0;
    end
  end

endmodule

// File: rtl/demux_hold_n.sv
// Registered 1-to-N demultiplexer with per-channel valid/ready buffers, a one-hot
// record of the last steered address and a saturating count of dropped words.
module demux_hold_n
  import demux_hold_n_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int ADDR_W    = 5,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [WIDTH-1:0]             in_data,
  output logic [CHANNELS-1:0]          out_valid,
  input  logic [CHANNELS-1:0]          out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [CHANNELS-1:0]          sel_onehot,
  output logic                         err_pulse,
  output logic [ERR_W-1:0]             err_count
);

  // Handshake: a word moves on a rising clk edge when in_valid && in_ready, and a
  // channel word moves when out_valid[k] && out_ready[k]; in_ready never depends on
  // in_valid, and out_ready on an empty channel has no effect.

  localparam int ADDR_MAX_L = addr_max(CHANNELS);

  logic [CHANNELS-1:0] addr_hit;
  logic [CHANNELS-1:0] slot_ready;
  logic [CHANNELS-1:0] wr_en;
  logic                in_range;
  logic                xfer;

  always_comb begin
    addr_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_addr == ADDR_W'(k)) addr_hit[k] = 1'b1;
    end
  end

  assign in_range = (in_addr <= ADDR_W'(ADDR_MAX_L));
  // Out-of-range words are always accepted so the source never stalls on a bad address.
  assign in_ready = in_range ? |(addr_hit & slot_ready) : 1'b1;
  assign xfer     = in_valid && in_ready;
  assign wr_en    = {CHANNELS{xfer}} & addr_hit;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    chan_state_t slot_state;

    demux_slot #(
      .WIDTH     (WIDTH),
      .HOLD_LAST (HOLD_LAST)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[k]),
      .wr_data  (in_data),
      .wr_ready (slot_ready[k]),
      .rd_ready (out_ready[k]),
      .rd_data  (out_data[k*WIDTH +: WIDTH]),
      .state    (slot_state)
    );

    assign out_valid[k] = (slot_state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_onehot <= '0;
    end else if (xfer && in_range) begin
      sel_onehot <= addr_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= xfer && !in_range;
      if (xfer && !in_range && (err_count != ERR_SAT)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_hold_n.sv
// Bench for demux_hold_n: two instances (HOLD_LAST=0 and HOLD_LAST=1) share stimulus
// and are checked against a per-channel buffer model and a streaming queue.
module tb_demux_hold_n;
  localparam int W  = 32;
  localparam int CH = 4;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [AW-1:0]   in_addr = '0;
  logic [W-1:0]    in_data = '0;
  logic [CH-1:0]   out_ready = '0;

  logic            in_ready, h_in_ready;
  logic [CH-1:0]   out_valid, h_out_valid;
  logic [CH*W-1:0] out_data, h_out_data;
  logic [CH-1:0]   sel_onehot, h_sel_onehot;
  logic            err_pulse, h_err_pulse;
  logic [7:0]      err_count, h_err_count;

  demux_hold_n #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW), .HOLD_LAST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_onehot(sel_onehot), .err_pulse(err_pulse), .err_count(err_count)
  );

  demux_hold_n #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW), .HOLD_LAST(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_addr(in_addr), .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_data(h_out_data), .sel_onehot(h_sel_onehot), .err_pulse(h_err_pulse),
    .err_count(h_err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel is a one-word box, d0 tracks HOLD_LAST=0, d1 HOLD_LAST=1.
  logic [CH-1:0] m_valid;
  logic [W-1:0]  m_d0[CH];
  logic [W-1:0]  m_d1[CH];
  logic [CH-1:0] m_sel;
  logic          m_errp;
  int            m_errc;
  logic [W-1:0]  exp_q[$];

  function automatic logic model_ready();
    if (in_addr < CH) return !m_valid[in_addr] || out_ready[in_addr];
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_valid = '0;
    m_sel   = '0;
    m_errp  = 1'b0;
    m_errc  = 0;
    for (int k = 0; k < CH; k++) begin
      m_d0[k] = '0;
      m_d1[k] = '0;
    end
  endtask

  task automatic model_tick();
    logic taken;
    taken  = in_valid && model_ready();
    m_errp = taken && (in_addr >= CH);
    if (m_errp && m_errc < 255) m_errc++;
    for (int k = 0; k < CH; k++) begin
      if (taken && in_addr == k) begin
        m_valid[k] = 1'b1;
        m_d0[k]    = in_data;
        m_d1[k]    = in_data;
      end else if (m_valid[k] && out_ready[k]) begin
        m_valid[k] = 1'b0;
        m_d0[k]    = '0;
      end
    end
    if (taken && in_addr < CH) m_sel = CH'(1) << in_addr;
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = '0;
    rst_n     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #2;
    n_cmp++;
    if (out_valid !== '0 || out_data !== '0 || sel_onehot !== '0 || err_pulse !== 1'b0
        || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_init: valid=%b sel=%b errp=%b errc=%0d data=%h, required all 0",
               out_valid, sel_onehot, err_pulse, err_count, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_addr = 5'd2; in_data = 32'h1234_5678;
    cycle();
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h0;
    cycle();
    n_cmp++;
    if (out_valid !== 4'b0100 || err_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre: valid=%b errp=%b, required 0100/1", out_valid, err_pulse);
    end
    // Assert reset mid-cycle while traffic is still being presented.
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (out_valid !== '0 || out_data !== '0 || sel_onehot !== '0 || err_pulse !== 1'b0
        || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_async: valid=%b sel=%b errp=%b errc=%0d, required all 0",
               out_valid, sel_onehot, err_pulse, err_count);
    end
    n_cmp++;
    if (h_out_valid !== '0 || h_out_data !== '0 || h_err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_async_h: valid=%b errc=%0d, required 0", h_out_valid, h_err_count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ch2_empty: valid=%b, required ch2 0", out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = '0;
    in_valid = 1'b1; in_addr = 5'd1; in_data = 32'hDEAD_BEEF;
    cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_valid: got %b, required 0010", out_valid);
    end
    n_cmp++;
    if (out_data[1*W +: W] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL single_data: got %h, required deadbeef", out_data[1*W +: W]);
    end
    n_cmp++;
    if (sel_onehot !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_sel: got %b, required 0010", sel_onehot);
    end
    out_ready = 4'b0010;
    cycle();
    out_ready = '0;
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] a, b;
    a = $urandom(); b = $urandom();
    in_valid = 1'b1; in_addr = 5'd0; in_data = a;
    cycle();
    in_data = b;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_ready_low: got %b, required 0", in_ready);
    end
    cycle();
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[0 +: W] !== a) begin
      n_bad++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1/%h", out_valid[0], out_data[0 +: W], a);
    end
    out_ready = 4'b0001;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready_high: got %b, required 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    out_ready = '0;
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[0 +: W] !== b) begin
      n_bad++;
      $display("FAIL bp_reload: valid=%b data=%h, required 1/%h", out_valid[0], out_data[0 +: W], b);
    end
    out_ready = 4'b1111;
    cycle();
    out_ready = '0;
  endtask

  task automatic test_streaming();
    int run;
    logic [W-1:0] exp;
    run = 0;
    out_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 5'd3; in_data = W'(i);
      exp_q.push_back(W'(i));
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_ready: word %0d in_ready=%b, required 1", i, in_ready);
      end
      cycle();
      if (out_valid[3] === 1'b1 && exp_q.size() > 0) begin
        run++;
        exp = exp_q.pop_front();
        n_cmp++;
        if (out_data[3*W +: W] !== exp) begin
          n_bad++;
          $display("FAIL stream_data: got %h, required %h", out_data[3*W +: W], exp);
        end
      end
    end
    in_valid = 1'b0;
    cycle();
    n_cmp++;
    if (run != 8 || out_valid[3] !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_run: valid cycles=%0d tail valid=%b left=%0d, required 8/0/0",
               run, out_valid[3], exp_q.size());
    end
    exp_q.delete();
    out_ready = '0;
  endtask

  task automatic test_bad_addr();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_addr = 5'd5; in_data = $urandom();
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bad_ready: iter %0d got %b, required 1", i, in_ready);
      end
      cycle();
      n_cmp++;
      if (err_pulse !== 1'b1 || out_valid !== '0 || err_count !== 8'(m_errc)) begin
        n_bad++;
        $display("FAIL bad_iter: iter %0d errp=%b valid=%b errc=%0d, required 1/0000/%0d",
                 i, err_pulse, out_valid, err_count, m_errc);
      end
    end
    in_valid = 1'b0;
    cycle();
    n_cmp++;
    if (err_count !== 8'd255 || err_pulse !== 1'b0 || sel_onehot !== '0) begin
      n_bad++;
      $display("FAIL bad_final: errc=%0d errp=%b sel=%b, required 255/0/0000",
               err_count, err_pulse, sel_onehot);
    end
  endtask

  task automatic test_parallel();
    out_ready = '0;
    for (int k = 0; k < CH; k++) begin
      in_valid = 1'b1; in_addr = AW'(k); in_data = $urandom() | 32'h1;
      cycle();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b1111 || h_out_valid !== 4'b1111) begin
      n_bad++;
      $display("FAIL par_full: valid=%b/%b, required 1111", out_valid, h_out_valid);
    end
    out_ready = 4'b1111;
    cycle();
    out_ready = '0;
    n_cmp++;
    if (out_valid !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL par_clear: valid=%b data=%h, required 0", out_valid, out_data);
    end
    for (int k = 0; k < CH; k++) begin
      n_cmp++;
      if (h_out_valid[k] !== 1'b0 || h_out_data[k*W +: W] !== m_d1[k]) begin
        n_bad++;
        $display("FAIL par_hold ch%0d: valid=%b data=%h, required 0/%h",
                 k, h_out_valid[k], h_out_data[k*W +: W], m_d1[k]);
      end
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(4, 31)) : AW'($urandom_range(0, 3));
      in_data   = $urandom();
      out_ready = CH'($urandom_range(0, 15));
      #1;
      exp_ready = model_ready();
      n_cmp++;
      if (in_ready !== exp_ready || h_in_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rnd_ready: iter %0d got %b/%b, required %b", i, in_ready, h_in_ready, exp_ready);
      end
      cycle();
      n_cmp++;
      if (out_valid !== m_valid || h_out_valid !== m_valid || sel_onehot !== m_sel
          || err_pulse !== m_errp || err_count !== 8'(m_errc)) begin
        n_bad++;
        $display("FAIL rnd_ctrl: iter %0d valid=%b sel=%b errp=%b errc=%0d, required %b/%b/%b/%0d",
                 i, out_valid, sel_onehot, err_pulse, err_count, m_valid, m_sel, m_errp, m_errc);
      end
      for (int k = 0; k < CH; k++) begin
        n_cmp++;
        if (out_data[k*W +: W] !== m_d0[k] || h_out_data[k*W +: W] !== m_d1[k]) begin
          n_bad++;
          $display("FAIL rnd_data: iter %0d ch%0d got %h/%h, required %h/%h", i, k,
                   out_data[k*W +: W], h_out_data[k*W +: W], m_d0[k], m_d1[k]);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = '0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_back_pressure();
    test_streaming();
    test_bad_addr();
    test_parallel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
